// File: rtl/write_buffer_if.sv
// Port bundles for the posted-write buffer: CPU load/store side and memory bus side.
interface write_buffer_cpu_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     i_rw;
    logic                     i_request;
    logic                     o_ready;
    logic [ADDRESS_WIDTH-1:0] i_address;
    logic [31:0]              o_rdata;
    logic [31:0]              i_wdata;
    logic [3:0]               i_wmask;
    logic                     o_empty;
    logic                     o_full;

    modport master (
        output i_rw, i_request, i_address, i_wdata, i_wmask,
        input  o_ready, o_rdata, o_empty, o_full
    );
    modport slave (
        input  i_rw, i_request, i_address, i_wdata, i_wmask,
        output o_ready, o_rdata, o_empty, o_full
    );
endinterface

interface write_buffer_bus_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     o_bus_rw;
    logic                     o_bus_request;
    logic                     i_bus_ready;
    logic [ADDRESS_WIDTH-1:0] o_bus_address;
    logic [31:0]              i_bus_rdata;
    logic [31:0]              o_bus_wdata;
    logic [3:0]               o_bus_wmask;

    modport master (
        output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_bus_wmask,
        input  i_bus_ready, i_bus_rdata
    );
    modport slave (
        input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_bus_wmask,
        output i_bus_ready, i_bus_rdata
    );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer: writes are queued and acked at once, drained in order to the bus;
// reads go to the bus, optionally waiting for the queue to drain first.
module write_buffer #(
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 32,
    parameter bit STALL_READ    = 1'b1
) (
    input logic                i_clock,
    input logic                i_reset,
    write_buffer_cpu_if.slave  cpu,
    write_buffer_bus_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic [31:0]              wdata;
        logic [3:0]               wmask;
    } entry_t;

    typedef enum logic [1:0] {IDLE, READ_WAIT, RELEASE} cpu_state_t;
    typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ, B_GAP} bus_state_t;

    entry_t                   fifo [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic [PW:0]              count_next;
    cpu_state_t               c_state;
    bus_state_t               b_state;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     read_go;

    // An in-flight write stays counted until its pop, so count==0 also means nothing in flight.
    always_comb begin
        fifo_full  = (count == FULL_COUNT);
        fifo_empty = (count == '0);
        push       = (c_state == IDLE) && cpu.i_request && cpu.i_rw && !fifo_full;
        pop        = (b_state == B_WRITE) && bus.i_bus_ready;
        read_go    = (c_state == READ_WAIT) && (!STALL_READ || fifo_empty);
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cpu.o_empty <= 1'b1;
            cpu.o_full  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            cpu.o_empty <= (count_next == '0);
            cpu.o_full  <= (count_next == FULL_COUNT);
        end
    end

    // Entry storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge i_clock) begin
        if (push)
            fifo[wr_ptr] <= '{address: cpu.i_address, wdata: cpu.i_wdata, wmask: cpu.i_wmask};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            c_state      <= IDLE;
            cpu.o_ready  <= 1'b0;
            cpu.o_rdata  <= '0;
            read_address <= '0;
        end else begin
            cpu.o_ready <= 1'b0;
            case (c_state)
                IDLE: begin
                    if (cpu.i_request) begin
                        if (cpu.i_rw) begin
                            if (!fifo_full) begin
                                cpu.o_ready <= 1'b1;
                                c_state     <= RELEASE;
                            end
                        end else begin
                            read_address <= cpu.i_address;
                            c_state      <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (b_state == B_READ && bus.i_bus_ready) begin
                        cpu.o_rdata <= bus.i_bus_rdata;
                        cpu.o_ready <= 1'b1;
                        c_state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!cpu.i_request)
                        c_state <= IDLE;
                end
                default: c_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            b_state           <= B_IDLE;
            bus.o_bus_request <= 1'b0;
            bus.o_bus_rw      <= 1'b0;
            bus.o_bus_address <= '0;
            bus.o_bus_wdata   <= '0;
            bus.o_bus_wmask   <= '0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    if (read_go) begin
                        bus.o_bus_request <= 1'b1;
                        bus.o_bus_rw      <= 1'b0;
                        bus.o_bus_address <= read_address;
                        bus.o_bus_wmask   <= '0;
                        b_state           <= B_READ;
                    end else if (!fifo_empty) begin
                        bus.o_bus_request <= 1'b1;
                        bus.o_bus_rw      <= 1'b1;
                        bus.o_bus_address <= fifo[rd_ptr].address;
                        bus.o_bus_wdata   <= fifo[rd_ptr].wdata;
                        bus.o_bus_wmask   <= fifo[rd_ptr].wmask;
                        b_state           <= B_WRITE;
                    end
                end
                B_WRITE, B_READ: begin
                    if (bus.i_bus_ready) begin
                        bus.o_bus_request <= 1'b0;
                        b_state           <= B_GAP;
                    end
                end
                // Request stays low here so a lingering ready never completes the next transaction.
                B_GAP:   b_state <= B_IDLE;
                default: b_state <= B_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_write_buffer.sv
// Randomized scoreboard bench for write_buffer (DEPTH=4, STALL_READ=1) against a reference memory.
module tb_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    write_buffer_cpu_if #(.ADDRESS_WIDTH(AW)) cif();
    write_buffer_bus_if #(.ADDRESS_WIDTH(AW)) bif();

    write_buffer #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .STALL_READ(1'b1)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .cpu(cif),
        .bus(bif)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } txn_t;

    txn_t        exp_bus[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    int tests = 0, fails = 0;
    int req_count = 0, ready_count = 0;
    bit stall = 1'b0, fixed_rdata = 1'b0;
    int max_delay = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Stimulus side: the expected bus transaction and read data are queued as the request is raised.
    task automatic start_op(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask);
        txn_t t;
        logic [31:0] cur;
        @(negedge clk);
        t.rw = rw; t.addr = addr; t.data = data; t.mask = mask;
        exp_bus.push_back(t);
        cur = ref_mem.exists(addr) ? ref_mem[addr] : 32'hdeadbeef;
        if (rw) ref_mem[addr] = merge(cur, data, mask);
        else    exp_rdata.push_back(fixed_rdata ? 32'hdeadbeef : cur);
        cif.i_rw = rw; cif.i_address = addr; cif.i_wdata = data; cif.i_wmask = mask;
        cif.i_request = 1'b1;
        req_count++;
    endtask

    task automatic finish_op(input bit hold_extra);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (cif.o_ready) seen = 1'b1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL op_timeout: no o_ready for address %h", cif.i_address);
        end
        if (hold_extra) @(negedge clk);
        cif.i_request = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (exp_bus.size() == 0 && !bif.o_bus_request) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d bus transactions outstanding", exp_bus.size());
        end
        repeat (3) @(negedge clk);
        check("empty_after_drain", cif.o_empty, 1'b1);
        check("full_after_drain", cif.o_full, 1'b0);
    endtask

    // Memory bus responder: random completion delay, optional stall, byte-masked memory.
    initial begin
        int waited, delay;
        logic [31:0] cur;
        waited = 0; delay = 0;
        bif.i_bus_ready = 1'b0;
        bif.i_bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bif.i_bus_ready) begin
                bif.i_bus_ready = 1'b0;
            end else if (rst) begin
                waited = 0;
            end else if (bif.o_bus_request && !stall) begin
                if (waited >= delay) begin
                    cur = bus_mem.exists(bif.o_bus_address) ? bus_mem[bif.o_bus_address] : 32'hdeadbeef;
                    bif.i_bus_ready = 1'b1;
                    if (bif.o_bus_rw) bus_mem[bif.o_bus_address] = merge(cur, bif.o_bus_wdata, bif.o_bus_wmask);
                    else bif.i_bus_rdata = fixed_rdata ? 32'hdeadbeef : cur;
                    waited = 0;
                    delay = int'($urandom_range(0, max_delay));
                end else begin
                    waited++;
                end
            end
        end
    end

    // Bus monitor: each new request must match the next expected transaction and hold steady.
    initial begin
        bit prev_req;
        txn_t cur;
        prev_req = 1'b0;
        cur = '{rw: 1'b0, addr: '0, data: '0, mask: '0};
        forever begin
            @(negedge clk);
            if (bif.o_bus_request && !prev_req) begin
                if (exp_bus.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_bus_txn: rw %0b address %h", bif.o_bus_rw, bif.o_bus_address);
                end else begin
                    cur = exp_bus.pop_front();
                    check("bus_rw", bif.o_bus_rw, cur.rw);
                    check("bus_address", bif.o_bus_address, cur.addr);
                    if (cur.rw) check("bus_wdata_mask", {bif.o_bus_wdata, bif.o_bus_wmask}, {cur.data, cur.mask});
                end
            end else if (bif.o_bus_request) begin
                check("bus_hold", {bif.o_bus_rw, bif.o_bus_address}, {cur.rw, cur.addr});
                if (cur.rw) check("bus_hold_data", {bif.o_bus_wdata, bif.o_bus_wmask}, {cur.data, cur.mask});
            end
            prev_req = bif.o_bus_request;
        end
    end

    // CPU monitor: o_ready is a single-cycle pulse; read completions carry the expected data.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cif.o_ready) begin
                ready_count++;
                check("ready_pulse_width", prev, 1'b0);
                if (!cif.i_rw) begin
                    if (exp_rdata.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_read_ready: rdata %h", cif.o_rdata);
                    end else begin
                        check("read_data", cif.o_rdata, exp_rdata.pop_front());
                    end
                end
            end
            prev = cif.o_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        logic rw;
        logic [31:0] addr;
        rst = 1'b1;
        cif.i_request = 1'b0; cif.i_rw = 1'b0; cif.i_address = '0; cif.i_wdata = '0; cif.i_wmask = '0;
        repeat (3) @(negedge clk);
        check("reset_empty", cif.o_empty, 1'b1);
        check("reset_full", cif.o_full, 1'b0);
        check("reset_bus_request", bif.o_bus_request, 1'b0);
        check("reset_ready", cif.o_ready, 1'b0);
        check("reset_rdata", cif.o_rdata, 32'h0);
        check("reset_bus_outputs", {bif.o_bus_rw, bif.o_bus_address, bif.o_bus_wdata, bif.o_bus_wmask}, 69'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_bus_request", bif.o_bus_request, 1'b0);
        check("idle_empty", cif.o_empty, 1'b1);

        // single write with the request held one cycle past o_ready
        start_op(1'b1, 32'hcafe0001, 32'hb00b1111, 4'b1111);
        finish_op(1'b1);
        @(negedge clk);
        check("ready_low_after_release", cif.o_ready, 1'b0);
        wait_drain();

        // eight back-to-back writes, then a read that must wait for all of them
        for (int k = 1; k <= 8; k++) begin
            start_op(1'b1, 32'hcafe0000 + k, 32'hb00b0000 + k * 32'h1111, 4'b1111);
            finish_op(1'b0);
        end
        fixed_rdata = 1'b1;
        start_op(1'b0, 32'hcafe0005, 32'h0, 4'h0);
        finish_op(1'b0);
        fixed_rdata = 1'b0;
        wait_drain();

        // fill the queue against a stalled bus; the fifth write must wait for space
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_op(1'b1, 32'h2000 + 4 * k, $urandom, 4'b1111);
            finish_op(1'b0);
        end
        @(negedge clk);
        check("full_after_fourth", cif.o_full, 1'b1);
        start_op(1'b1, 32'h2010, $urandom, 4'b1111);
        got = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (cif.o_ready) got = 1'b1;
        end
        check("no_ready_when_full", got, 1'b0);
        stall = 1'b0;
        finish_op(1'b0);
        for (int k = 0; k < 5; k++) begin
            start_op(1'b1, 32'h2000 + 4 * k, $urandom, 4'($urandom));
            finish_op(1'b0);
        end
        start_op(1'b0, 32'h2010, 32'h0, 4'h0);
        finish_op(1'b0);
        wait_drain();

        // randomized mix of masked writes and reads over a small address set
        max_delay = 3;
        for (int n = 0; n < 60; n++) begin
            rw = ($urandom_range(0, 9) < 7);
            addr = 32'h1000 + 4 * $urandom_range(0, 7);
            start_op(rw, addr, $urandom, 4'($urandom));
            finish_op(1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

        // reset while a write is in flight discards everything queued
        stall = 1'b1;
        start_op(1'b1, 32'h3000, 32'h11112222, 4'b1111);
        finish_op(1'b0);
        start_op(1'b1, 32'h3004, 32'h33334444, 4'b1111);
        finish_op(1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bif.o_bus_request) got = 1'b1;
        end
        check("inflight_before_reset", got, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_drops_request", bif.o_bus_request, 1'b0);
        check("reset_sets_empty", cif.o_empty, 1'b1);
        rst = 1'b0;
        exp_bus.delete();
        stall = 1'b0;
        got = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bif.o_bus_request) got = 1'b1;
        end
        check("no_bus_after_reset", got, 1'b0);
        check("ready_count", ready_count, req_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/write_buffer.md
# write_buffer

Posted-write buffer between a CPU-side load/store port and a slower memory bus. Writes are queued in a FIFO and acknowledged immediately. Queued writes are drained to the bus in order, one transaction at a time. Reads go to the bus and, when configured, wait until all queued writes have completed, which preserves read-after-write ordering.

## Interface
- DEPTH, 16: number of FIFO entries; power of two, ≥2.
- ADDRESS_WIDTH, 32: width of the address on both ports.
- STALL_READ, 1: 1 = a read waits until the FIFO is empty and no write is in flight; 0 = a read is issued as soon as the bus is idle, overtaking queued writes (the caller guarantees no address hazard).

Ports (one clock; reset is synchronous and active-high):
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- o_empty  out  1  FIFO count is 0 and no bus write is in flight.
- o_full  out  1  FIFO count equals DEPTH.
- o_bus_rw  out  1  1 = bus write, 0 = bus read.
- o_bus_request  out  1  bus transaction request.
- i_bus_ready  in  1  bus completion; valid only while o_bus_request is high.
- o_bus_address  out  ADDRESS_WIDTH  bus address.
- i_bus_rdata  in  32  bus read data.
- o_bus_wdata  out  32  bus write data.
- o_bus_wmask  out  4  bus byte enables.
- i_rw  in  1  1 = write, 0 = read.
- i_request  in  1  CPU request; held high until o_ready is seen, then dropped.
- o_ready  out  1  one-cycle completion pulse.
- i_address  in  ADDRESS_WIDTH  CPU address.
- o_rdata  out  32  read data; valid when o_ready pulses for a read.
- i_wdata  in  32  CPU write data.
- i_wmask  in  4  CPU byte enables.

## Operation
- FIFO entry: {address, wdata, wmask}. Read and write pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- CPU-side FSM, states IDLE, READ_WAIT, RELEASE:
  - IDLE, write request, FIFO not full: push the entry, pulse o_ready, go to RELEASE.
  - IDLE, write request, FIFO full: no action; retry each cycle until a slot frees.
  - IDLE, read request: go to READ_WAIT.
  - READ_WAIT: when the bus engine is idle (and, if STALL_READ=1, o_empty=1), issue the bus read.
  - READ_WAIT, on i_bus_ready: latch i_bus_rdata into o_rdata, pulse o_ready, go to RELEASE.
  - RELEASE: wait until i_request is sampled low, then go to IDLE. A request still high after its o_ready is never accepted twice.
- Bus engine, states B_IDLE, B_WRITE, B_READ, B_GAP:
  - B_IDLE: a pending read (when allowed) has priority. Otherwise, if the FIFO is non-empty, issue the head entry as a write in B_WRITE.
  - B_WRITE / B_READ: hold o_bus_request and all bus outputs stable until i_bus_ready is sampled high. On a write, pop the FIFO. Then go to B_GAP.
  - B_GAP: one cycle with o_bus_request low, then B_IDLE. This guarantees a stale ready is never taken for the next transaction.
- Simultaneous push and pop in one cycle: count is unchanged, both pointers advance.
- A push while full is impossible by construction, because the request is stalled.
- o_rdata holds its value until the next read completes.

## Timing
- Reset values: count, pointers, o_ready, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask and o_rdata are all 0. o_empty=1, o_full=0. Both FSMs return to their idle states.
- Reset mid-transaction: queued and in-flight writes are discarded and the bus request drops on the next cycle.
- All outputs are registered.
- Write latency: i_request sampled at edge t with space free → o_ready high for the cycle after t only.
- Drain: head entry sampled at edge t → o_bus_request high after t. The transaction is complete at the edge where i_bus_ready=1, and o_bus_request is low after that edge.
- Read, STALL_READ=1: o_ready comes 1 cycle after the bus ready of the read. That read starts only after the last queued write completes and its B_GAP cycle has passed.
- o_full and o_empty update in the cycle after the push or pop.

## Test plan
- Reset, then idle: o_empty=1, o_full=0, o_bus_request=0, o_ready=0.
- Single write {0xcafe0001, 0xb00b1111, 4'b1111}, with request held one extra cycle after o_ready:
  - exactly one o_ready pulse;
  - exactly one bus write with that address, data and mask;
  - o_ready=0 two cycles after the pulse.
- Eight back-to-back writes (0xcafe0001..0xcafe0008, data 0xb00b1111..0xb00b8888), bus acknowledging 1 cycle after each request:
  - bus writes appear in order, none lost or duplicated;
  - o_empty=1 at the end.
- Read of 0xcafe0005 right after those eight writes, STALL_READ=1, bus returning 0xdeadbeef:
  - the bus read occurs only after the 8th write completes;
  - o_rdata=0xdeadbeef when o_ready pulses.
- DEPTH=4 with the bus stalled: the 4th write sets o_full=1 and the 5th write gets no o_ready. After the bus is released, the 5th write completes and pointer wrap-around preserves order.
- Reset asserted while a bus write is in flight: o_bus_request=0 and o_empty=1 on the next cycle, and no further bus writes occur.
